mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the EX stage. It accepts one LoongArch multiply operation at a time (mul.w, mulh.w, mulh.wu) and converts signed operands to magnitudes. It drives the external 32-row unsigned partial-product array, accumulates ROWS_PER_CYCLE rows per cycle into a 64-bit sum, and applies the sign fix-up. The result is returned on a valid/ready response port.

---
 rtl/mul_seq.sv | 160 ++++++++++++++++
 tb/tb_mul_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq -- multi-cycle multiply sequencer for the EX stage.
//
// Handles one LoongArch multiply at a time (mul.w, mulh.w, mulh.wu).
// Signed operands are converted to magnitudes and fed to an external 32-row
// unsigned partial-product array. ROWS_PER_CYCLE rows are summed into a
// 64-bit accumulator each cycle, the sign is fixed up, and the selected
// half is returned on a valid/ready response port.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_ready is high only when idle
//   req_op               00 mul.w, 01 mulh.w, 10/11 mulh.wu
//   src1, src2           operands
//   flush                synchronous kill of any in-flight operation
//   resp_valid/ready     response handshake
//   resp_result          registered result, held until the next fix-up
//   busy                 block is not idle
//   arr_m, arr_r         registered multiplicand/multiplier magnitudes
//   arr_pp               array rows, row k = arr_pp[32k+31:32k]
module mul_seq #(
    parameter int ROWS_PER_CYCLE = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [31:0]   src1,
    input  logic [31:0]   src2,
    input  logic          flush,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_result,
    output logic          busy,
    output logic [31:0]   arr_m,
    output logic [31:0]   arr_r,
    input  logic [1023:0] arr_pp
);

    localparam int CYCLES = 32 / ROWS_PER_CYCLE;
    // cnt runs 0..CYCLES: one extra ACCUM cycle drains the row-sum register.
    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES);

    typedef enum logic [1:0] {IDLE, ACCUM, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [63:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       res_q;
    logic [63:0]       sum_p1;
    logic              vld_p1;
    logic              accept;
    logic [63:0]       row_sum_p0;
    logic [4:0]        cnt_base;
    logic [4:0]        row_idx;
    logic [31:0]       row;
    logic [63:0]       acc_fixed;

    function automatic logic [31:0] magnitude(input logic signed [31:0] x);
        // 0x80000000 maps to itself, read as unsigned 2^31.
        return x[31] ? 32'(-x) : 32'(x);
    endfunction

    function automatic logic [63:0] sign_fix(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] pick_half(input logic [63:0] v, input logic [1:0] op);
        return (op == 2'b00) ? v[31:0] : v[63:32];
    endfunction

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---- FSM: next state and outputs ----
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        resp_valid  = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                accept    = req_valid && !flush;
                if (accept) state_nxt = ACCUM;
            end
            ACCUM:   if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign resp_result = res_q;
    assign acc_fixed   = sign_fix(acc, neg_q);

    // ---- stage p0: sum this cycle's rows, each shifted by its row index ----
    always_comb begin
        row_sum_p0 = '0;
        row_idx    = '0;
        row        = '0;
        cnt_base   = 5'(int'(cnt) * ROWS_PER_CYCLE);
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            row_idx    = cnt_base + 5'(j);
            row        = arr_pp[{row_idx, 5'd0} +: 32];
            row_sum_p0 = row_sum_p0 + ({32'd0, row} << row_idx);
        end
    end

    // ---- stage p1: accumulate, sign fix-up, result register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arr_m  <= '0;
            arr_r  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            res_q  <= '0;
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            sum_p1 <= row_sum_p0;
            vld_p1 <= (state == ACCUM) && (cnt != CNT_LAST) && !flush;
            if (accept) begin
                op_q <= req_op;
                acc  <= '0;
                cnt  <= '0;
                if (req_op == 2'b01) begin
                    arr_m <= magnitude(src1);
                    arr_r <= magnitude(src2);
                    neg_q <= src1[31] ^ src2[31];
                end else begin
                    arr_m <= src1;
                    arr_r <= src2;
                    neg_q <= 1'b0;
                end
            end else if (state == ACCUM && !flush) begin
                cnt <= cnt + CNT_W'(1);
                if (vld_p1) acc <= acc + sum_p1;
            end else if (state == FIX && !flush) begin
                acc   <= acc_fixed;
                res_q <= pick_half(acc_fixed, op_q);
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: four instances (ROWS_PER_CYCLE = 4, 8, 16, 32) share
// one stimulus stream; each lane has its own partial-product array and a
// behavioural model built from the multiply rules and the latency formula.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;

    logic        req_ready   [4];
    logic        resp_valid  [4];
    logic        busy        [4];
    logic [31:0] resp_result [4];
    logic [31:0] arr_m       [4];
    logic [31:0] arr_r       [4];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [1023:0] pp;
        always_comb begin
            pp = '0;
            for (int k = 0; k < 32; k++)
                pp[32*k +: 32] = arr_r[g][k] ? arr_m[g] : 32'h0;
        end
        mul_seq #(.ROWS_PER_CYCLE(4 << g)) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .req_valid  (req_valid),
            .req_ready  (req_ready[g]),
            .req_op     (req_op),
            .src1       (src1),
            .src2       (src2),
            .flush      (flush),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready),
            .resp_result(resp_result[g]),
            .busy       (busy[g]),
            .arr_m      (arr_m[g]),
            .arr_r      (arr_r[g]),
            .arr_pp     (pp)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int lat_of(input int g);
        return 32 / (4 << g) + 2;
    endfunction

    function automatic logic [31:0] tb_mag(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return up[31:0];
            2'b01:   return sp[63:32];
            default: return up[63:32];
        endcase
    endfunction

    // Behavioural model: an accepted op is busy for lat_of(g) cycles, then
    // presents its result until handshaken; flush discards, reset clears.
    logic        m_busy [4] = '{default: 1'b0};
    logic        m_done [4] = '{default: 1'b0};
    int          m_rem  [4] = '{default: 0};
    logic [31:0] m_exp  [4] = '{default: 32'h0};
    logic [31:0] m_last [4] = '{default: 32'h0};
    logic [31:0] m_am   [4] = '{default: 32'h0};
    logic [31:0] m_ar   [4] = '{default: 32'h0};

    always @(posedge clk or negedge resetn) begin
        for (int g = 0; g < 4; g++) begin
            if (!resetn) begin
                m_busy[g] <= 1'b0; m_done[g] <= 1'b0; m_rem[g] <= 0;
                m_exp[g] <= '0; m_last[g] <= '0; m_am[g] <= '0; m_ar[g] <= '0;
            end else if (flush) begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
            end else if (!m_busy[g]) begin
                if (req_valid) begin
                    m_busy[g] <= 1'b1;
                    m_rem[g]  <= lat_of(g);
                    m_exp[g]  <= ref_result(req_op, src1, src2);
                    m_am[g]   <= (req_op == 2'b01) ? tb_mag(src1) : src1;
                    m_ar[g]   <= (req_op == 2'b01) ? tb_mag(src2) : src2;
                end
            end else if (!m_done[g]) begin
                if (m_rem[g] == 1) begin
                    m_done[g] <= 1'b1;
                    m_last[g] <= m_exp[g];
                end
                m_rem[g] <= m_rem[g] - 1;
            end else if (resp_ready) begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
            end
        end
    end

    // Compare every lane against the model on the falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("lane%0d req_ready", g),   req_ready[g],   !m_busy[g]);
            chk($sformatf("lane%0d busy", g),        busy[g],        m_busy[g]);
            chk($sformatf("lane%0d resp_valid", g),  resp_valid[g],  m_done[g]);
            chk($sformatf("lane%0d resp_result", g), resp_result[g], m_last[g]);
            chk($sformatf("lane%0d arr_m", g),       arr_m[g],       m_am[g]);
            chk($sformatf("lane%0d arr_r", g),       arr_r[g],       m_ar[g]);
        end
    end

    function automatic logic all_valid();
        return resp_valid[0] && resp_valid[1] && resp_valid[2] && resp_valid[3];
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output int l1);
        int          lat [4];
        logic [31:0] res [4];
        for (int g = 0; g < 4; g++) begin lat[g] = 0; res[g] = '0; end
        req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++)
                if (resp_valid[g] && lat[g] == 0) begin
                    lat[g] = n;
                    res[g] = resp_result[g];
                end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("lane%0d latency op%0d", g, op), lat[g], lat_of(g));
            chk($sformatf("lane%0d result %h*%h op%0d", g, a, b, op), res[g],
                ref_result(op, a, b));
        end
        r1 = res[1];
        l1 = lat[1];
    endtask

    task automatic wait_all_valid(input string name);
        int n;
        n = 0;
        while (!all_valid() && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " resp_valid timeout"}, all_valid(), 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        int          l;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset req_ready", req_ready[g], 1'b1);
            chk("reset busy", busy[g], 1'b0);
            chk("reset resp_valid", resp_valid[g], 1'b0);
            chk("reset resp_result", resp_result[g], 32'h0);
            chk("reset arr_m", arr_m[g], 32'h0);
        end
        resetn = 1'b1;
        @(posedge clk); #1;

        // mul.w basic, busy through the latency window.
        req_valid = 1'b1; req_op = 2'b00; src1 = 32'd7; src2 = 32'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        l = 0;
        for (int n = 1; n <= 12 && l == 0; n++) begin
            chk("basic busy", busy[1], 1'b1);
            @(posedge clk); #1;
            if (resp_valid[1]) begin l = n; r = resp_result[1]; end
        end
        chk("basic latency", l, 6);
        chk("basic result", r, 32'h0000_002A);
        repeat (8) @(posedge clk);
        #1;

        // Signed and unsigned corners.
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, r, l); chk("mulh min*min", r, 32'h4000_0000);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, r, l); chk("mulh -1*1", r, 32'hFFFF_FFFF);
        do_op(2'b01, 32'h8000_0000, 32'h0000_0001, r, l); chk("mulh min*1", r, 32'hFFFF_FFFF);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l); chk("mulhwu ff*ff", r, 32'hFFFF_FFFE);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l); chk("mulw ff*ff", r, 32'h0000_0001);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l); chk("op11 ff*ff", r, 32'hFFFF_FFFE);
        chk("mulw latency", l, 6);

        // Backpressure.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; src1 = 32'h1234; src2 = 32'h5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_all_valid("backpressure");
        r = resp_result[1];
        chk("backpressure result", r, 32'h0626_0060);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp resp_valid held", resp_valid[1], 1'b1);
            chk("bp resp_result held", resp_result[1], r);
            chk("bp req_ready low", req_ready[1], 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp idle after handshake", req_ready[1], 1'b1);
        chk("bp resp_valid dropped", resp_valid[1], 1'b0);
        chk("bp result kept", resp_result[1], r);

        // Flush in the second ACCUM cycle.
        req_valid = 1'b1; req_op = 2'b00; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush accum idle", req_ready[1], 1'b1);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk("flush accum no resp", resp_valid[1] | resp_valid[0], 1'b0);
        end

        // Flush in DONE.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b10; src1 = 32'd100; src2 = 32'd100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_all_valid("flush done");
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        resp_ready = 1'b1;
        chk("flush done resp_valid", resp_valid[1] | resp_valid[3], 1'b0);
        chk("flush done req_ready", req_ready[1], 1'b1);

        // Flush together with a request in IDLE.
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; src1 = 32'd2; src2 = 32'd2;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush+req no accept", busy[1], 1'b0);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            chk("flush+req no resp", resp_valid[1], 1'b0);
        end
        do_op(2'b00, 32'd3, 32'd5, r, l);
        chk("after flush 3*5", r, 32'd15);

        // Asynchronous reset mid-ACCUM, between clock edges.
        req_valid = 1'b1; req_op = 2'b01; src1 = 32'hFFFF_FFF0; src2 = 32'd77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("async req_ready", req_ready[g], 1'b1);
            chk("async busy", busy[g], 1'b0);
            chk("async resp_valid", resp_valid[g], 1'b0);
            chk("async resp_result", resp_result[g], 32'h0);
            chk("async arr_m", arr_m[g], 32'h0);
            chk("async arr_r", arr_r[g], 32'h0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Random sweep, all four widths in lock-step.
        for (int i = 0; i < 1000; i++)
            do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), r, l);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
